// File: rtl/seg_pkg.sv
// Shared types, glyph table and helpers for the seven-segment character scanner.
// Cathode constants are active-low {CA,CB,CC,CD,CE,CF,CG,DP} with the DP bit off.
package seg_pkg;

  localparam logic [3:0] CODE_BLANK = 4'hF;
  localparam int         CODE_MAX_W = 16;

  localparam logic [7:0] CATH_G   = 8'h09;
  localparam logic [7:0] CATH_L   = 8'hE3;
  localparam logic [7:0] CATH_I   = 8'hF7;
  localparam logic [7:0] CATH_D   = 8'h85;
  localparam logic [7:0] CATH_E   = 8'h61;
  localparam logic [7:0] CATH_R   = 8'hF5;
  localparam logic [7:0] CATH_B   = 8'hC1;
  localparam logic [7:0] CATH_A   = 8'h11;
  localparam logic [7:0] CATH_N   = 8'hD5;
  localparam logic [7:0] CATH_K   = 8'h51;
  localparam logic [7:0] CATH_O   = 8'hC5;
  localparam logic [7:0] CATH_C   = 8'hE5;
  localparam logic [7:0] CATH_OFF = 8'hFF;

  typedef enum logic {
    UPD_IDLE    = 1'b0,
    UPD_PENDING = 1'b1
  } upd_state_e;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Callers zero-extend the character code, so any set upper bit lands in default.
  function automatic logic [6:0] seg_decode(input logic [CODE_MAX_W-1:0] code);
    logic [7:0] cath;
    case (code)
      16'd0:   cath = CATH_G;
      16'd1:   cath = CATH_L;
      16'd2:   cath = CATH_I;
      16'd3:   cath = CATH_D;
      16'd4:   cath = CATH_E;
      16'd5:   cath = CATH_R;
      16'd6:   cath = CATH_B;
      16'd7:   cath = CATH_A;
      16'd8:   cath = CATH_N;
      16'd9:   cath = CATH_K;
      16'd10:  cath = CATH_O;
      16'd11:  cath = CATH_C;
      default: cath = CATH_OFF;
    endcase
    return cath[7:1];
  endfunction

endpackage

// File: rtl/seg_refresh_timer.sv
// Digit-slot timer: tick counts 0..DIGIT_TICKS-1 inside a slot, idx selects the digit,
// frame_end marks the last tick of the last digit.
module seg_refresh_timer
  import seg_pkg::*;
#(
  parameter  int CLK_HZ      = 100_000_000,
  parameter  int DIGIT_HZ    = 8_000,
  parameter  int NUM_DIGITS  = 8,
  localparam int DIGIT_TICKS = CLK_HZ / DIGIT_HZ,
  localparam int TICK_W      = clog2_min1(DIGIT_TICKS),
  localparam int IDX_W       = clog2_min1(NUM_DIGITS)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [TICK_W-1:0] tick_o,
  output logic [IDX_W-1:0]  idx_o,
  output logic              frame_end_o
);

  logic [TICK_W-1:0] tick_q, tick_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              tick_tc;
  logic              idx_last;

  assign tick_tc  = (tick_q == TICK_W'(DIGIT_TICKS - 1));
  assign idx_last = (idx_q == IDX_W'(NUM_DIGITS - 1));

  always_comb begin
    tick_d = tick_tc ? '0 : tick_q + TICK_W'(1);
    idx_d  = idx_q;
    if (tick_tc) begin
      idx_d = idx_last ? '0 : idx_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_q <= '0;
      idx_q  <= '0;
    end else begin
      tick_q <= tick_d;
      idx_q  <= idx_d;
    end
  end

  assign tick_o      = tick_q;
  assign idx_o       = idx_q;
  assign frame_end_o = tick_tc && idx_last;

endmodule

// File: rtl/seg_char_scanner.sv
// Multiplexed common-anode 7-segment driver with dead-time and frame-synchronous updates.
// Optional message scrolling is enabled by defining SEG_SCROLL_EN.
module seg_char_scanner
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 8,
  parameter int CHAR_W        = 4,
  parameter int CLK_HZ        = 100_000_000,
  parameter int DIGIT_HZ      = 8_000,
  parameter int DEAD_TICKS    = 64,
  parameter int MSG_LEN       = 16,
  parameter int SCROLL_FRAMES = 250
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef SEG_SCROLL_EN
  input  logic [MSG_LEN*CHAR_W-1:0]    chars_i,
`else
  input  logic [NUM_DIGITS*CHAR_W-1:0] chars_i,
`endif
  input  logic [NUM_DIGITS-1:0]        dp_i,
  input  logic                         blank_i,
  input  logic                         upd_req_i,
  output logic                         upd_busy_o,
  output logic                         upd_ack_o,
  output logic [NUM_DIGITS-1:0]        anode_o,
  output logic [7:0]                   cathode_o
);

  localparam int DIGIT_TICKS = CLK_HZ / DIGIT_HZ;
  localparam int TICK_W      = clog2_min1(DIGIT_TICKS);
  localparam int IDX_W       = clog2_min1(NUM_DIGITS);
`ifdef SEG_SCROLL_EN
  localparam int NUM_CHARS   = MSG_LEN;
`else
  localparam int NUM_CHARS   = NUM_DIGITS;
`endif
  localparam int BUF_W = NUM_CHARS * CHAR_W;
  localparam logic [BUF_W-1:0] BUF_BLANK = {NUM_CHARS{CHAR_W'(CODE_BLANK)}};

  if (DIGIT_TICKS < 2 || DEAD_TICKS >= DIGIT_TICKS || DEAD_TICKS < 0 ||
      CHAR_W < 4 || CHAR_W > CODE_MAX_W || NUM_DIGITS < 1 ||
      MSG_LEN < 1 || SCROLL_FRAMES < 1) begin : g_bad_params
    $error("seg_char_scanner: invalid parameter set");
  end

  logic [TICK_W-1:0] tick;
  logic [IDX_W-1:0]  idx;
  logic              frame_end;

  seg_refresh_timer #(
    .CLK_HZ     (CLK_HZ),
    .DIGIT_HZ   (DIGIT_HZ),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_timer (
    .clk         (clk),
    .rst_n       (rst_n),
    .tick_o      (tick),
    .idx_o       (idx),
    .frame_end_o (frame_end)
  );

  // Update handshake: a request is accepted only in a cycle where upd_busy_o is low
  // (upd_req_i && !upd_busy_o). Once accepted, upd_busy_o stays high until the staged
  // characters are copied to the display at a frame boundary, which is signalled by a
  // single-cycle upd_ack_o. Requests seen while busy are dropped, staging untouched.
  upd_state_e upd_state_q, upd_state_d;
  logic       capture;
  logic       commit;

  assign capture = upd_req_i && (upd_state_q == UPD_IDLE);
  assign commit  = frame_end && (upd_state_q == UPD_PENDING);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) upd_state_q <= UPD_IDLE;
    else        upd_state_q <= upd_state_d;
  end

  always_comb begin
    upd_state_d = upd_state_q;
    case (upd_state_q)
      UPD_IDLE:    if (capture) upd_state_d = UPD_PENDING;
      UPD_PENDING: if (commit)  upd_state_d = UPD_IDLE;
      default:     upd_state_d = UPD_IDLE;
    endcase
  end

  always_comb begin
    upd_busy_o = (upd_state_q == UPD_PENDING);
  end

  logic [BUF_W-1:0] stage_q, stage_d;
  logic [BUF_W-1:0] disp_q, disp_d;
  logic             ack_q, ack_d;

  always_comb begin
    stage_d = stage_q;
    disp_d  = disp_q;
    ack_d   = 1'b0;
    if (capture) stage_d = chars_i;
    if (commit) begin
      disp_d = stage_q;
      ack_d  = 1'b1;
    end
  end

`ifdef SEG_SCROLL_EN
  localparam int OFF_W = clog2_min1(MSG_LEN);
  localparam int FRM_W = clog2_min1(SCROLL_FRAMES);

  logic [OFF_W-1:0] offset_q, offset_d;
  logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    offset_d    = offset_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_end) begin
      if (frame_cnt_q == FRM_W'(SCROLL_FRAMES - 1)) begin
        frame_cnt_d = '0;
        offset_d    = (offset_q == OFF_W'(MSG_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
      end else begin
        frame_cnt_d = frame_cnt_q + FRM_W'(1);
      end
    end
    // A fresh message always starts from its first character.
    if (commit) offset_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      offset_q    <= offset_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
`endif

  int                    char_pos;
  logic [CHAR_W-1:0]     cur_char;
  logic [CODE_MAX_W-1:0] code_ext;

  always_comb begin
    char_pos = int'(idx);
`ifdef SEG_SCROLL_EN
    char_pos = char_pos + int'(offset_q);
    if (char_pos >= NUM_CHARS) char_pos = char_pos - NUM_CHARS;
`endif
    cur_char = CHAR_W'(CODE_BLANK);
    for (int k = 0; k < NUM_CHARS; k++) begin
      if (char_pos == k) cur_char = disp_q[k*CHAR_W +: CHAR_W];
    end
    code_ext                = '0;
    code_ext[CHAR_W-1:0]    = cur_char;
  end

  logic [NUM_DIGITS-1:0] anode_q, anode_d;
  logic [7:0]            cathode_q, cathode_d;

  always_comb begin
    anode_d = '1;
    if (!blank_i && (tick >= TICK_W'(DEAD_TICKS))) begin
      anode_d = ~(NUM_DIGITS'(1) << idx);
    end
    cathode_d = {seg_decode(code_ext), ~dp_i[idx]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q   <= BUF_BLANK;
      disp_q    <= BUF_BLANK;
      ack_q     <= 1'b0;
      anode_q   <= '1;
      cathode_q <= CATH_OFF;
    end else begin
      stage_q   <= stage_d;
      disp_q    <= disp_d;
      ack_q     <= ack_d;
      anode_q   <= anode_d;
      cathode_q <= cathode_d;
    end
  end

  assign upd_ack_o = ack_q;
  assign anode_o   = anode_q;
  assign cathode_o = cathode_q;

endmodule

// File: tb/tb_seg_char_scanner.sv
// Directed bench for seg_char_scanner: 4 digits, 10 ticks per slot, 2 dead ticks.
// cyc counts rising edges since reset release; outputs at cyc k reflect timer state k-1.
`timescale 1ns/1ps
module tb_seg_char_scanner;

  localparam int NUM_DIGITS    = 4;
  localparam int CHAR_W        = 4;
  localparam int CLK_HZ        = 1000;
  localparam int DIGIT_HZ      = 100;
  localparam int DEAD_TICKS    = 2;
  localparam int MSG_LEN       = 6;
  localparam int SCROLL_FRAMES = 2;
`ifdef SEG_SCROLL_EN
  localparam int CHARS_W = MSG_LEN * CHAR_W;
`else
  localparam int CHARS_W = NUM_DIGITS * CHAR_W;
`endif

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic [CHARS_W-1:0]    chars_i = '0;
  logic [NUM_DIGITS-1:0] dp_i = '0;
  logic                  blank_i = 1'b0;
  logic                  upd_req_i = 1'b0;
  logic                  upd_busy_o;
  logic                  upd_ack_o;
  logic [NUM_DIGITS-1:0] anode_o;
  logic [7:0]            cathode_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  seg_char_scanner #(
    .NUM_DIGITS    (NUM_DIGITS),
    .CHAR_W        (CHAR_W),
    .CLK_HZ        (CLK_HZ),
    .DIGIT_HZ      (DIGIT_HZ),
    .DEAD_TICKS    (DEAD_TICKS),
    .MSG_LEN       (MSG_LEN),
    .SCROLL_FRAMES (SCROLL_FRAMES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .chars_i    (chars_i),
    .dp_i       (dp_i),
    .blank_i    (blank_i),
    .upd_req_i  (upd_req_i),
    .upd_busy_o (upd_busy_o),
    .upd_ack_o  (upd_ack_o),
    .anode_o    (anode_o),
    .cathode_o  (cathode_o)
  );

  always #5 clk = ~clk;

  task automatic adv_to(input int target);
    while (cyc < target) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic chk_an(input string tag, input logic [3:0] exp_v);
    chk(tag, 8'(anode_o), 8'(exp_v));
  endtask

  task automatic chk_hs(input string tag, input logic exp_busy, input logic exp_ack);
    chk({tag, "_busy"}, 8'(upd_busy_o), 8'(exp_busy));
    chk({tag, "_ack"},  8'(upd_ack_o),  8'(exp_ack));
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_an("rst_anode", 4'b1111);
    chk("rst_cathode", cathode_o, 8'hFF);
    chk_hs("rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    cyc   = 0;

`ifdef SEG_SCROLL_EN
    adv_to(1);   chars_i = 24'h543210; upd_req_i = 1'b1;
    adv_to(2);   upd_req_i = 1'b0; chk_hs("scr_cap", 1'b1, 1'b0);
    adv_to(40);  chk_hs("scr_commit", 1'b0, 1'b1);
    adv_to(41);  chk("scr_off0_d0", cathode_o, 8'h09);
    adv_to(71);  chk("scr_off0_d3", cathode_o, 8'h85);
    adv_to(81);  chk("scr_off1_d0", cathode_o, 8'hE3);
    adv_to(121); chk("scr_off1_hold", cathode_o, 8'hE3);
    adv_to(161); chk("scr_off2_d0", cathode_o, 8'hF7);
    adv_to(401); chk("scr_off5_d0", cathode_o, 8'hF5);
    adv_to(411); chk("scr_off5_d1_wrap", cathode_o, 8'h09);
    adv_to(431); chk("scr_off5_d3_wrap", cathode_o, 8'hF7);
    adv_to(481); chk("scr_off_wrap0", cathode_o, 8'h09);
    adv_to(520); chars_i = 24'hBA9876; upd_req_i = 1'b1;
    adv_to(521); upd_req_i = 1'b0; chk_hs("scr_cap2", 1'b1, 1'b0);
    adv_to(560); chk_hs("scr_commit2", 1'b0, 1'b1);
    adv_to(561); chk("scr_commit_wins", cathode_o, 8'hC1);
    adv_to(571); chk("scr_new_d1", cathode_o, 8'h11);
    adv_to(641); chk("scr_step_after_commit", cathode_o, 8'h11);
`else
    adv_to(1);   chk_an("dead0_a", 4'b1111); chk("blank_cath1", cathode_o, 8'hFF);
    adv_to(3);   chk_an("digit0_on", 4'b1110); chk("blank_cath3", cathode_o, 8'hFF);
    adv_to(5);   chars_i = 16'h3210; upd_req_i = 1'b1;
    adv_to(6);   upd_req_i = 1'b0; chk_hs("cap", 1'b1, 1'b0);
    adv_to(10);  chk_an("digit0_end", 4'b1110);
    chars_i = 16'h7777; upd_req_i = 1'b1;
    adv_to(11);  upd_req_i = 1'b0; chk_hs("req_while_busy", 1'b1, 1'b0);
    chk_an("dead1", 4'b1111);
    adv_to(13);  chk_an("digit1_on", 4'b1101);
    adv_to(23);  chk_an("digit2_on", 4'b1011);
    adv_to(33);  chk_an("digit3_on", 4'b0111);
    adv_to(39);  chk_hs("pre_commit", 1'b1, 1'b0);
    upd_req_i = 1'b1;
    adv_to(40);  upd_req_i = 1'b0; chk_hs("commit", 1'b0, 1'b1);
    chk("old_disp_at_commit", cathode_o, 8'hFF);
    adv_to(41);  chk_hs("req_on_clear_ignored", 1'b0, 1'b0);
    chk_an("wrap_dead", 4'b1111); chk("d0_g", cathode_o, 8'h09);
    adv_to(51);  chk("d1_L", cathode_o, 8'hE3);
    adv_to(61);  chk("d2_i", cathode_o, 8'hF7);
    adv_to(73);  chk_an("d3_anode", 4'b0111); chk("d3_d", cathode_o, 8'h85);
    adv_to(80);  dp_i = 4'b0010;
    adv_to(81);  chk("dp_d0_off", cathode_o, 8'h09);
    adv_to(91);  chk("dp_d1_on", cathode_o, 8'hE2);
    adv_to(101); chk("dp_d2_off", cathode_o, 8'hF7);
    adv_to(103); chk_an("pre_blank", 4'b1011); blank_i = 1'b1;
    adv_to(104); chk_an("blank_on", 4'b1111); chk("blank_cath", cathode_o, 8'hF7);
    adv_to(105); blank_i = 1'b0;
    adv_to(106); chk_an("blank_off", 4'b1011);
    adv_to(119); chars_i = 16'hC5A7; upd_req_i = 1'b1;
    adv_to(120); upd_req_i = 1'b0; chk_hs("cap_on_frame_end", 1'b1, 1'b0);
    adv_to(121); chk("no_early_commit", cathode_o, 8'h09);
    adv_to(159); chk_hs("pending_next_frame", 1'b1, 1'b0);
    adv_to(160); chk_hs("commit_next_frame", 1'b0, 1'b1);
    adv_to(161); chk("d0_A", cathode_o, 8'h11);
    adv_to(171); chk("d1_o_dp", cathode_o, 8'hC4);
    adv_to(181); chk("d2_r", cathode_o, 8'hF5);
    adv_to(191); chk("d3_code12", cathode_o, 8'hFF);
    adv_to(193); chk_an("d3_code12_anode", 4'b0111);
`endif

    dp_i      = '0;
    chars_i   = {(CHARS_W/4){4'h1}};
    upd_req_i = 1'b1;
    adv_to(cyc + 1);
    upd_req_i = 1'b0;
    chk_hs("pre_reset", 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk_an("async_rst_anode", 4'b1111);
    chk("async_rst_cathode", cathode_o, 8'hFF);
    chk_hs("async_rst", 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc   = 0;
    adv_to(3);  chk_an("post_rst_digit0", 4'b1110);
    adv_to(40); chk_hs("post_rst_discard", 1'b0, 1'b0);
    adv_to(41); chk("post_rst_blank", cathode_o, 8'hFF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
